// File: rtl/event_capture_mc_pkg.sv
// Shared types for the multi-source event capture stage: coordinates, FSM state
// and the source-tagged event held in the output queue.
package event_capture_mc_pkg;
   localparam int COORD_W      = 8;
   localparam int MAX_SRC_BITS = 8;

   typedef struct packed {
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } coord_t;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, CHECK} mc_capture_state_t;

   typedef struct packed {
      coord_t                  coord;
      logic [MAX_SRC_BITS-1:0] src;
   } src_event_t;

   function automatic coord_t unpack_coordinates(input logic [2*COORD_W-1:0] raw);
      coord_t c;
      c.y = raw[2*COORD_W-1:COORD_W];
      c.x = raw[COORD_W-1:0];
      return c;
   endfunction

   function automatic logic is_valid_coord(input coord_t c, input int width, input int height);
      return (32'(c.x) < width) && (32'(c.y) < height);
   endfunction
endpackage

// File: rtl/event_capture_mc_if.sv
// Bus between the event capture stage and its surroundings: source FIFOs in,
// tagged events out toward the convolution core, plus status.
interface event_capture_mc_if #(
   parameter int NUM_SOURCES = 4,
   parameter int COORD_BITS  = 8,
   parameter int SRC_BITS    = 2,
   parameter int CNT_BITS    = 16
);
   import event_capture_mc_pkg::*;

   logic                              enable_i;
   logic [NUM_SOURCES-1:0]            fifo_empty_i;
   logic [NUM_SOURCES*2*COORD_BITS-1:0] fifo_data_i;
   logic [NUM_SOURCES-1:0]            fifo_read_o;
   coord_t                            event_coord_o;
   logic [SRC_BITS-1:0]               event_src_o;
   logic                              event_valid_o;
   logic                              event_ready_i;
   logic [CNT_BITS-1:0]               dropped_count_o;
   logic                              busy_o;

   modport master (
      output enable_i, fifo_empty_i, fifo_data_i, event_ready_i,
      input  fifo_read_o, event_coord_o, event_src_o, event_valid_o, dropped_count_o, busy_o
   );

   modport slave (
      input  enable_i, fifo_empty_i, fifo_data_i, event_ready_i,
      output fifo_read_o, event_coord_o, event_src_o, event_valid_o, dropped_count_o, busy_o
   );
endinterface

// File: rtl/event_capture_mc_rr_arbiter.sv
// Rotating-priority arbiter: search starts one past the last granted requester.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                reset_i,
   input  logic [N-1:0]        req,
   input  logic                advance,
   output logic [N-1:0]        grant_oh,
   output logic [IDX_BITS-1:0] grant_idx,
   output logic                grant_vld
);
   logic [IDX_BITS-1:0] ptr_q;

   always_comb begin
      int idx;
      idx       = 0;
      grant_oh  = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (!grant_vld && req[IDX_BITS'(idx)]) begin
            grant_vld                  = 1'b1;
            grant_idx                  = IDX_BITS'(idx);
            grant_oh[IDX_BITS'(idx)]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i)      ptr_q <= '0;
      else if (advance) ptr_q <= (grant_idx == IDX_BITS'(N-1)) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/event_capture_mc.sv
// Multi-source event capture: round-robin pops one event per grant, bounds-checks it,
// queues accepted events with their source tag and counts the dropped ones.
module event_capture_mc
   import event_capture_mc_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int COORD_BITS  = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32,
   parameter int OUT_DEPTH   = 4,
   parameter int CNT_BITS    = 16
) (
   input logic               clk,
   input logic               reset_i,
   event_capture_mc_if.slave bus
);
   localparam int SRC_BITS = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
   localparam int PTR_BITS = $clog2(OUT_DEPTH);
   localparam int EV_BITS  = 2 * COORD_BITS;

   mc_capture_state_t      state_q, state_d;
   logic [SRC_BITS-1:0]    grant_q, arb_idx;
   logic [NUM_SOURCES-1:0] grant_oh_q, arb_oh;
   logic                   arb_vld, start, push, drop, pop, valid, q_full, chk_ok;
   coord_t                 chk_coord;
   logic [EV_BITS-1:0]     slot [NUM_SOURCES];
   src_event_t             mem [OUT_DEPTH];
   src_event_t             head;
   logic [PTR_BITS-1:0]    wr_ptr, rd_ptr;
   logic [PTR_BITS:0]      count_q;
   logic [CNT_BITS-1:0]    drop_q;

   for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_slot
      assign slot[k] = bus.fifo_data_i[k*EV_BITS +: EV_BITS];
   end

   rr_arbiter #(.N(NUM_SOURCES), .IDX_BITS(SRC_BITS)) u_arb (
      .clk      (clk),
      .reset_i  (reset_i),
      .req      (~bus.fifo_empty_i),
      .advance  (start),
      .grant_oh (arb_oh),
      .grant_idx(arb_idx),
      .grant_vld(arb_vld)
   );

   // The slot is reserved here, so CHECK can always push without looking at fullness.
   assign q_full    = (count_q == (PTR_BITS+1)'(OUT_DEPTH));
   assign start     = (state_q == IDLE) && bus.enable_i && arb_vld && !q_full;
   assign chk_coord = unpack_coordinates(slot[grant_q]);
   assign chk_ok    = is_valid_coord(chk_coord, IMG_WIDTH, IMG_HEIGHT);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = WAIT;
         WAIT:    state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.fifo_read_o = '0;
      push            = 1'b0;
      drop            = 1'b0;
      case (state_q)
         FETCH:   bus.fifo_read_o = grant_oh_q;
         CHECK: begin
            push = chk_ok;
            drop = !chk_ok;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         grant_q    <= '0;
         grant_oh_q <= '0;
      end else if (start) begin
         grant_q    <= arb_idx;
         grant_oh_q <= arb_oh;
      end
   end

   assign valid = (count_q != '0);
   assign pop   = valid && bus.event_ready_i;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{coord: chk_coord, src: MAX_SRC_BITS'(grant_q)};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i)                  drop_q <= '0;
      else if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
   end

   assign bus.event_coord_o   = head.coord;
   assign bus.event_src_o     = SRC_BITS'(head.src);
   assign bus.event_valid_o   = valid;
   assign bus.dropped_count_o = drop_q;
   assign bus.busy_o          = (state_q != IDLE) || valid;
endmodule
